// File: rtl/alu_tx_pkg.sv
// alu_tx_pkg
//   Shared types and constants for the ALU result serial transmitter.
//   Holds the transmitter FSM state enum, the frame geometry (bytes per
//   frame, bits per byte) and the level the data line rests at when
//   released.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    PAR,
    ACK,
    FIN
  } tx_state_e;

  localparam int FRAME_BYTES = 2;
  localparam int BYTE_W      = 8;
  localparam logic SDA_IDLE  = 1'b1;

endpackage

// File: rtl/alu_tx_bit_timer.sv
// alu_tx_bit_timer
//   Divides clk into serial bit slots of BIT_DIV cycles each. The divider
//   is held at zero while disabled, so the first enabled cycle is always
//   the first cycle of a slot.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         count enable (high while a frame is on the line)
//   bit_start  first cycle of the current slot
//   bit_end    last cycle of the current slot
module alu_tx_bit_timer
  import alu_tx_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_start,
  output logic bit_end
);

  localparam int DW = $clog2(BIT_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  logic [DW-1:0] div_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign bit_start = en && (div_q == '0);
  assign bit_end   = en && (div_q == DIV_LAST);

endmodule

// File: rtl/alu_result_tx.sv
// alu_result_tx
//   Captures the 16-bit ALU result {sum2_i, sum1_i} over a valid/ready
//   handshake and shifts it out on sda_o as two bytes, high byte first,
//   MSB first. Each byte is followed by a released acknowledge slot in
//   which ack_n_i is sampled on the slot's last cycle; a NACK aborts the
//   frame. Build option ALU_TX_PARITY_EN inserts an even-parity slot after
//   each byte, ahead of its acknowledge slot.
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   sum1_i        ALU low result byte
//   sum2_i        ALU high result byte
//   res_valid_i   result valid
//   res_ready_o   result can be accepted (IDLE, not in reset)
//   sda_o         serial data, rests high
//   sbit_o        strobe on the first cycle of every slot
//   ack_n_i       receiver acknowledge, 0 = ACK, 1 = NACK
//   busy_o        frame in progress
//   done_o        pulse when both bytes were acknowledged
//   nack_o        pulse when a frame was aborted by NACK
//
// state | meaning
// IDLE  | waiting for a result, ready high
// SEND  | shifting out the 8 bits of the current byte
// PAR   | parity slot for the current byte (ALU_TX_PARITY_EN only)
// ACK   | line released, ack_n_i sampled on last cycle
// FIN   | one-cycle done pulse
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sum1_i,
  input  logic [7:0] sum2_i,
  input  logic       res_valid_i,
  output logic       res_ready_o,
  output logic       sda_o,
  output logic       sbit_o,
  input  logic       ack_n_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o
);

  localparam int SR_W = FRAME_BYTES * BYTE_W;
  localparam logic [3:0] LAST_BIT  = 4'(BYTE_W - 1);
  localparam logic       LAST_BYTE = 1'(FRAME_BYTES - 1);

  tx_state_e       state_q, state_d;
  logic [SR_W-1:0] sreg_q;
  logic [3:0]      bit_cnt_q;
  logic            byte_q;
  logic            nack_q;
  logic            timer_en;
  logic            bit_start;
  logic            bit_end;
`ifdef ALU_TX_PARITY_EN
  logic            par_q;
`endif

  assign timer_en = (state_q == SEND) || (state_q == PAR) || (state_q == ACK);

  alu_tx_bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sda_o       = SDA_IDLE;
    res_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o      = 1'b0;
        res_ready_o = !rst;
        if (res_valid_i) state_d = SEND;
      end
      SEND: begin
        sda_o = sreg_q[SR_W-1];
        if (bit_end && (bit_cnt_q == LAST_BIT)) begin
`ifdef ALU_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = ACK;
`endif
        end
      end
      PAR: begin
`ifdef ALU_TX_PARITY_EN
        sda_o = par_q;
`endif
        if (bit_end) state_d = ACK;
      end
      ACK: begin
        if (bit_end) begin
          if (ack_n_i)                 state_d = IDLE;
          else if (byte_q == LAST_BYTE) state_d = FIN;
          else                         state_d = SEND;
        end
      end
      FIN: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sbit_o = bit_start;
  assign nack_o = nack_q;

  // Data already shifted out is never needed again, so the register simply
  // shifts left; after byte 0 the low byte sits in the top bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      byte_q    <= 1'b0;
      nack_q    <= 1'b0;
`ifdef ALU_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      nack_q <= (state_q == ACK) && bit_end && ack_n_i;
      case (state_q)
        IDLE: begin
          if (res_valid_i) begin
            sreg_q    <= {sum2_i, sum1_i};
            bit_cnt_q <= '0;
            byte_q    <= 1'b0;
`ifdef ALU_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (bit_end) begin
            sreg_q    <= {sreg_q[SR_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 4'd1;
`ifdef ALU_TX_PARITY_EN
            par_q     <= par_q ^ sreg_q[SR_W-1];
`endif
          end
        end
        ACK: begin
          if (bit_end && !ack_n_i && (byte_q != LAST_BYTE)) begin
            bit_cnt_q <= '0;
            byte_q    <= 1'b1;
`ifdef ALU_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
